// File: rtl/bp_pkg.sv
// Shared encodings and helper functions for the two-level branch predictor.
package bp_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam int MODE_LOCAL  = 0;
    localparam int MODE_GLOBAL = 1;
    localparam int MODE_GSHARE = 2;

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } sweep_state_t;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Caller truncates the result to the PHT index width (LSBs kept).
    function automatic logic [31:0] pht_hash(input logic [31:0] hist, input logic [31:0] pc,
                                             input int mode, input int hist_w);
        logic [31:0] pc_bits;
        logic [31:0] hashed;
        pc_bits = (pc >> 2) & ((32'd1 << hist_w) - 32'd1);
        hashed  = (mode == MODE_GSHARE) ? (hist ^ pc_bits) : hist;
        return hashed;
    endfunction

endpackage

// File: rtl/bp_init_sweep.sv
// Post-reset table initialisation: walks every table index once, then parks in READY.
module bp_init_sweep
    import bp_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             sweep_we,
    output logic             init_done
);

    sweep_state_t     r_state;
    sweep_state_t     w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SWEEP;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        if (r_state == SWEEP) begin
            w_idx_next = r_idx + 1'b1;
            if (r_idx == {IDX_W{1'b1}}) begin
                w_state_next = READY;
            end
        end
    end

    always_comb begin
        sweep_we  = (r_state == SWEEP);
        init_done = (r_state == READY);
    end

    assign idx = r_idx;

endmodule

// File: rtl/bp_two_level.sv
// Two-level conditional branch predictor (local / global / gshare) with
// speculative global history, mispredict repair and sequential table init.
module bp_two_level
    import bp_pkg::*;
#(
    parameter int MODE      = 2,
    parameter int BHT_DEPTH = 10,
    parameter int HIST_W    = 6,
    parameter int PHT_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flushD,
    input  logic              stallD,
    input  logic [31:0]       instrD,
    input  logic [31:0]       pcF,
    input  logic [31:0]       pcM,
    input  logic              branchM,
    input  logic              actual_takeM,
    input  logic              pred_takeM,
    input  logic [HIST_W-1:0] ghrM,
    output logic              branchD,
    output logic              branchL_D,
    output logic              pred_takeD,
    output logic [HIST_W-1:0] ghrD,
    output logic              init_done
);

    localparam int IDX_W    = (PHT_DEPTH > BHT_DEPTH) ? PHT_DEPTH : BHT_DEPTH;
    localparam int PHT_SIZE = 1 << PHT_DEPTH;

    logic [IDX_W-1:0]     w_idx;
    logic                 w_sweep_we;
    logic                 w_init_done;

    logic                 w_regimm;
    logic [HIST_W-1:0]    w_hist_f;
    logic [HIST_W-1:0]    w_hist_m;
    logic [PHT_DEPTH-1:0] w_pht_idx_f;
    logic [PHT_DEPTH-1:0] w_pht_idx_m;
    logic                 w_pred_f;
    logic [HIST_W-1:0]    w_hist_d;
    logic                 w_mispred;
    logic                 w_spec_shift;
    logic                 w_pht_in_rng;
    logic                 w_pht_we;
    logic [PHT_DEPTH-1:0] w_pht_waddr;
    logic [1:0]           w_pht_wdata;

    logic [1:0]           r_pht [PHT_SIZE];
    logic [HIST_W-1:0]    r_ghr;
    logic                 r_pred;
    logic [HIST_W-1:0]    r_ghrD;

    bp_init_sweep #(.IDX_W(IDX_W)) u_sweep (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (w_idx),
        .sweep_we  (w_sweep_we),
        .init_done (w_init_done)
    );

    assign w_regimm  = (instrD[31:26] == 6'b000001);
    assign branchD   = (w_regimm && (instrD[19:17] == 3'b000 || instrD[19:17] == 3'b001))
                     || (instrD[31:28] == 4'b0001);
    assign branchL_D = (w_regimm && (instrD[19:17] == 3'b001))
                     || (instrD[31:28] == 4'b0101);

    // Local mode owns a per-PC history table; the global modes use GHR / the carried checkpoint.
    if (MODE == MODE_LOCAL) begin : g_local
        localparam int BHT_SIZE = 1 << BHT_DEPTH;

        logic [HIST_W-1:0]    r_bht [BHT_SIZE];
        logic [BHT_DEPTH-1:0] w_bht_idx_f;
        logic [BHT_DEPTH-1:0] w_bht_idx_m;
        logic                 w_bht_in_rng;
        logic                 w_bht_we;
        logic [BHT_DEPTH-1:0] w_bht_waddr;
        logic [HIST_W-1:0]    w_bht_wdata;

        assign w_bht_idx_f = pcF[BHT_DEPTH+1:2];
        assign w_bht_idx_m = pcM[BHT_DEPTH+1:2];
        assign w_hist_f    = r_bht[w_bht_idx_f];
        assign w_hist_m    = r_bht[w_bht_idx_m];

        if (IDX_W > BHT_DEPTH) begin : g_bht_rng
            assign w_bht_in_rng = ~|w_idx[IDX_W-1:BHT_DEPTH];
        end else begin : g_bht_full
            assign w_bht_in_rng = 1'b1;
        end

        always_comb begin
            w_bht_we    = 1'b0;
            w_bht_waddr = w_bht_idx_m;
            w_bht_wdata = {w_hist_m[HIST_W-2:0], actual_takeM};
            if (w_sweep_we) begin
                w_bht_we    = w_bht_in_rng;
                w_bht_waddr = w_idx[BHT_DEPTH-1:0];
                w_bht_wdata = '0;
            end else if (branchM) begin
                w_bht_we = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (w_bht_we) begin
                r_bht[w_bht_waddr] <= w_bht_wdata;
            end
        end
    end else begin : g_global
        assign w_hist_f = r_ghr;
        assign w_hist_m = ghrM;
    end

    assign w_pht_idx_f = PHT_DEPTH'(pht_hash(32'(w_hist_f), pcF, MODE, HIST_W));
    assign w_pht_idx_m = PHT_DEPTH'(pht_hash(32'(w_hist_m), pcM, MODE, HIST_W));
    assign w_pred_f    = w_init_done & r_pht[w_pht_idx_f][1];
    assign w_hist_d    = w_init_done ? w_hist_f : '0;

    if (IDX_W > PHT_DEPTH) begin : g_pht_rng
        assign w_pht_in_rng = ~|w_idx[IDX_W-1:PHT_DEPTH];
    end else begin : g_pht_full
        assign w_pht_in_rng = 1'b1;
    end

    // The sweep owns the write port until init completes; training is ignored meanwhile.
    always_comb begin
        w_pht_we    = 1'b0;
        w_pht_waddr = w_pht_idx_m;
        w_pht_wdata = ctr_next(r_pht[w_pht_idx_m], actual_takeM);
        if (w_sweep_we) begin
            w_pht_we    = w_pht_in_rng;
            w_pht_waddr = w_idx[PHT_DEPTH-1:0];
            w_pht_wdata = WT;
        end else if (branchM) begin
            w_pht_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pht_we) begin
            r_pht[w_pht_waddr] <= w_pht_wdata;
        end
    end

    assign w_mispred    = branchM & (pred_takeM ^ actual_takeM);
    assign w_spec_shift = branchD & ~stallD & ~flushD;

    // Repair from the checkpoint wins over a same-cycle speculative shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (MODE != MODE_LOCAL && w_init_done) begin
            if (w_mispred) begin
                r_ghr <= {ghrM[HIST_W-2:0], actual_takeM};
            end else if (w_spec_shift) begin
                r_ghr <= {r_ghr[HIST_W-2:0], pred_takeD};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred <= 1'b0;
            r_ghrD <= '0;
        end else if (flushD) begin
            r_pred <= 1'b0;
            r_ghrD <= '0;
        end else if (!stallD) begin
            r_pred <= w_pred_f;
            r_ghrD <= w_hist_d;
        end
    end

    assign pred_takeD = branchD & r_pred;
    assign ghrD       = r_ghrD;
    assign init_done  = w_init_done;

    // Not every address / history bit participates in every mode.
    logic w_unused;
    assign w_unused = ^{instrD, pcF, pcM, ghrM, w_hist_m};

endmodule

// File: tb/tb_bp_two_level.sv
// Directed bench for bp_two_level: one instance per history mode, scoreboard-checked.
module tb_bp_two_level;

    localparam logic [31:0] BEQ = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n;

    logic [2:0]       flushD, stallD, branchM, actual_takeM, pred_takeM;
    logic [2:0][31:0] instrD, pcF, pcM;
    logic [2:0][5:0]  ghrM;
    logic [2:0]       bD, bL, pT, iD;
    logic [2:0][5:0]  gD;

    always #5 clk = ~clk;

    // Instance gi runs history mode gi: 0 local, 1 global, 2 gshare.
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        bp_two_level #(.MODE(gi), .BHT_DEPTH(10), .HIST_W(6), .PHT_DEPTH(8)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .flushD       (flushD[gi]),
            .stallD       (stallD[gi]),
            .instrD       (instrD[gi]),
            .pcF          (pcF[gi]),
            .pcM          (pcM[gi]),
            .branchM      (branchM[gi]),
            .actual_takeM (actual_takeM[gi]),
            .pred_takeM   (pred_takeM[gi]),
            .ghrM         (ghrM[gi]),
            .branchD      (bD[gi]),
            .branchL_D    (bL[gi]),
            .pred_takeD   (pT[gi]),
            .ghrD         (gD[gi]),
            .init_done    (iD[gi])
        );
    end

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) begin
                n_pass++;
                $display("check %s: observed %0h expected %0h ok", e.tag, obs, e.val);
            end else begin
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic train(input int k, input logic [31:0] pc, input logic [5:0] gm,
                         input logic act, input logic pm);
        branchM[k]      = 1'b1;
        pcM[k]          = pc;
        ghrM[k]         = gm;
        actual_takeM[k] = act;
        pred_takeM[k]   = pm;
        to_next();
        branchM[k]      = 1'b0;
    endtask

    // Fetch cycle, then a beq in D whose prediction is checked.
    task automatic probe(input int k, input string tag, input logic exp_pred);
        instrD[k] = '0;
        to_next();
        instrD[k] = BEQ;
        push(tag, 32'(exp_pred));
        to_neg();
        check(32'(pT[k]));
        to_next();
        instrD[k] = '0;
    endtask

    task automatic wait_init(output int cycles);
        cycles = 0;
        while (!iD[1] && cycles < 2000) begin
            to_next();
            cycles++;
        end
    endtask

    logic [31:0] dec_instr [8] = '{32'h1000_0000, 32'h1C00_0000, 32'h0401_0000, 32'h0403_0000,
                                   32'h0410_0000, 32'h0404_0000, 32'h5000_0000, 32'h0800_0000};
    logic [1:0]  dec_exp   [8] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b00};

    initial begin
        int cycles;
        flushD = '0; stallD = '0; branchM = '0; actual_takeM = '0; pred_takeM = '0;
        instrD = '0; pcF = '0; pcM = '0; ghrM = '0;
        rst_n  = 1'b0;

        // Reset state and init latency
        to_neg();
        push("rst_init_done", 0); check(32'(iD[1]));
        push("rst_ghrD", 0);      check(32'(gD[1]));
        push("rst_pred", 0);      check(32'(pT[1]));
        to_neg();
        rst_n = 1'b1;
        wait_init(cycles);
        push("init_latency", 1024); check(32'(cycles));
        push("init_all", 7);        check(32'(iD));

        // Global: counter walk at history 0
        probe(1, "g_first_beq", 1'b1);
        train(1, 32'h100, 6'h00, 1'b0, 1'b1);
        train(1, 32'h100, 6'h00, 1'b0, 1'b0);
        train(1, 32'h100, 6'h00, 1'b0, 1'b0);
        probe(1, "g_nt_sat", 1'b0);
        train(1, 32'h100, 6'h00, 1'b1, 1'b1);
        probe(1, "g_wnt", 1'b0);
        train(1, 32'h100, 6'h00, 1'b1, 1'b1);
        train(1, 32'h100, 6'h00, 1'b1, 1'b1);
        train(1, 32'h100, 6'h00, 1'b1, 1'b1);
        train(1, 32'h100, 6'h00, 1'b0, 1'b0);
        probe(1, "g_t_sat", 1'b1);

        // Global: mispredict repair beats a same-cycle speculative shift
        instrD[1] = BEQ;
        train(1, 32'h200, 6'h03, 1'b0, 1'b1);
        instrD[1] = '0;
        to_next();
        instrD[1] = BEQ;
        push("g_repair_ghr", 32'h06); push("g_repair_pred", 1);
        to_neg(); check(32'(gD[1])); check(32'(pT[1]));
        to_next();
        instrD[1] = '0;
        to_next();

        // Global: stall holds D register for 3 cycles, flush clears it
        stallD[1] = 1'b1;
        instrD[1] = BEQ;
        branchM[1] = 1'b1; pcM[1] = 32'h0; ghrM[1] = 6'h2A; actual_takeM[1] = 1'b1; pred_takeM[1] = 1'b0;
        push("g_stall0_ghr", 32'h0D);
        to_neg(); check(32'(gD[1]));
        to_next();
        branchM[1] = 1'b0;
        push("g_stall1_ghr", 32'h0D); push("g_stall1_pred", 1);
        to_neg(); check(32'(gD[1])); check(32'(pT[1]));
        to_next();
        push("g_stall2_ghr", 32'h0D);
        to_neg(); check(32'(gD[1]));
        to_next();
        flushD[1] = 1'b1;
        to_next();
        flushD[1] = 1'b0; stallD[1] = 1'b0;
        push("g_flush_pred", 0); push("g_flush_ghr", 0);
        to_neg(); check(32'(pT[1])); check(32'(gD[1]));
        to_next();
        instrD[1] = '0;
        push("g_post_flush_ghr", 32'h15);
        to_neg(); check(32'(gD[1]));
        to_next();

        // Gshare: GHR 101010 with pcF[7:2] 010101 hits PHT[63]
        train(2, 32'hFC, 6'h00, 1'b0, 1'b0);
        train(2, 32'hFC, 6'h00, 1'b0, 1'b0);
        train(2, 32'h00, 6'h15, 1'b0, 1'b1);
        pcF[2] = 32'h54;
        to_next();
        instrD[2] = BEQ;
        pcF[2] = 32'h50;
        push("s_idx63_pred", 0); push("s_ghrD", 32'h2A);
        to_neg(); check(32'(pT[2])); check(32'(gD[2]));
        to_next();
        push("s_idx62_pred", 1);
        to_neg(); check(32'(pT[2]));
        to_next();
        instrD[2] = '0;

        // Local: three taken resolutions at pcM 0x40
        train(0, 32'h40, 6'h00, 1'b1, 1'b1);
        train(0, 32'h40, 6'h00, 1'b1, 1'b1);
        train(0, 32'h40, 6'h00, 1'b1, 1'b1);
        pcF[0] = 32'h40;
        to_next();
        instrD[0] = BEQ;
        push("l_bht16", 32'h07); push("l_pred", 1);
        to_neg(); check(32'(gD[0])); check(32'(pT[0]));
        pcF[0] = 32'h44;
        to_next();
        push("l_bht17", 32'h00);
        to_neg(); check(32'(gD[0]));
        to_next();

        // Decode of branch / likely-branch classes
        for (int i = 0; i < 8; i++) begin
            instrD[0] = dec_instr[i];
            push($sformatf("decode_%0d", i), 32'(dec_exp[i]));
            to_neg();
            check(32'({bD[0], bL[0]}));
            to_next();
        end
        instrD[0] = '0;

        // Async reset, then a reset pulse mid-sweep restarts the sweep
        to_neg();
        rst_n = 1'b0;
        #1;
        push("async_rst_done", 0); check(32'(iD[1]));
        push("async_rst_ghrD", 0); check(32'(gD[1]));
        to_neg();
        rst_n = 1'b1;
        repeat (600) to_next();
        push("midsweep_done", 0); check(32'(iD[1]));
        to_neg();
        rst_n = 1'b0;
        to_neg();
        rst_n = 1'b1;
        wait_init(cycles);
        push("restart_latency", 1024); check(32'(cycles));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
